paula_audio_mix_seq: RTL and testbench

Sequencer that time-shares a single 8x6 signed-by-unsigned volume multiplier across the four Paula audio channels. On each sample tick it snapshots all channel samples, volumes and enables, multiplies them one channel per cycle, and accumulates the products into left (channels 0, 3) and right (channels 1, 2) mixes. It sits between the four audio channel state machines and the audio output DAC/sigma-delta stage, replacing four parallel multipliers with one.

---
 rtl/paula_audio_pkg.sv | 24 ++
 rtl/paula_audio_volume.sv | 16 +
 rtl/paula_audio_mix_seq.sv | 137 +++++++++++++
 tb/tb_paula_audio_mix_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/paula_audio_pkg.sv
// Shared definitions for the Paula audio mix sequencer: FSM encoding, datapath
// widths, channel routing and the product sign-extension helper.
package paula_audio_pkg;

   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = 8;
   localparam int VOL_W    = 6;
   localparam int PROD_W   = 14;
   localparam int MIX_W    = 15;

   // Bit n set routes channel n to the left mix, clear routes it right.
   localparam logic [NUM_CH-1:0] LEFT_MASK = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   function automatic logic signed [MIX_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {p[PROD_W-1], p};
   endfunction

endpackage

// File: rtl/paula_audio_volume.sv
// Shared 8x6 signed-by-unsigned volume multiplier; the full product range
// (-8064..+8001) fits a 14-bit signed result exactly.
module paula_audio_volume
   import paula_audio_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  logic        [VOL_W-1:0]    volume_i,
   output logic signed [PROD_W-1:0]   product_o
);

   logic signed [VOL_W:0] vol_signed_s;

   assign vol_signed_s = $signed({1'b0, volume_i});
   assign product_o    = PROD_W'(sample_i) * PROD_W'(vol_signed_s);

endmodule

// File: rtl/paula_audio_mix_seq.sv
// Time-shares one volume multiplier across the four Paula channels: snapshot on
// start, one channel per cycle into left/right accumulators, then publish.
module paula_audio_mix_seq
   import paula_audio_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic signed [SAMPLE_W-1:0] sample0,
   input  logic signed [SAMPLE_W-1:0] sample1,
   input  logic signed [SAMPLE_W-1:0] sample2,
   input  logic signed [SAMPLE_W-1:0] sample3,
   input  logic        [VOL_W-1:0]    volume0,
   input  logic        [VOL_W-1:0]    volume1,
   input  logic        [VOL_W-1:0]    volume2,
   input  logic        [VOL_W-1:0]    volume3,
   input  logic        [NUM_CH-1:0]   chan_en,
   output logic signed [MIX_W-1:0]    left,
   output logic signed [MIX_W-1:0]    right,
   output logic                       done,
   output logic                       busy,
   output logic                       overrun
);

   state_e                     state_q;
   logic [1:0]                 ch_q;
   logic signed [SAMPLE_W-1:0] smp_q [NUM_CH];
   logic        [VOL_W-1:0]    vol_q [NUM_CH];
   logic        [NUM_CH-1:0]   en_q;
   logic signed [MIX_W-1:0]    acc_l_q, acc_r_q, acc_l_d, acc_r_d;
   logic signed [MIX_W-1:0]    left_q, right_q, term_s;
   logic                       done_q, busy_q, overrun_q;
   logic signed [SAMPLE_W-1:0] mul_smp_s;
   logic        [VOL_W-1:0]    mul_vol_s;
   logic signed [PROD_W-1:0]   prod_s;

   assign mul_smp_s = smp_q[ch_q];
   assign mul_vol_s = vol_q[ch_q];

   paula_audio_volume u_volume (
      .sample_i  (mul_smp_s),
      .volume_i  (mul_vol_s),
      .product_o (prod_s)
   );

   // Gate the current channel's product and route it into the proper accumulator.
   always_comb begin
      term_s  = {MIX_W{1'b0}};
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      if (en_q[ch_q]) begin
         term_s = sext_prod(prod_s);
      end else begin
         term_s = {MIX_W{1'b0}};
      end
      if (LEFT_MASK[ch_q]) begin
         acc_l_d = acc_l_q + term_s;
      end else begin
         acc_r_d = acc_r_q + term_s;
      end
   end

   // Sequencer FSM with snapshot, accumulators and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ch_q      <= 2'd0;
         en_q      <= {NUM_CH{1'b0}};
         acc_l_q   <= {MIX_W{1'b0}};
         acc_r_q   <= {MIX_W{1'b0}};
         left_q    <= {MIX_W{1'b0}};
         right_q   <= {MIX_W{1'b0}};
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            smp_q[i] <= {SAMPLE_W{1'b0}};
            vol_q[i] <= {VOL_W{1'b0}};
         end
      end else begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  smp_q[0] <= sample0;
                  smp_q[1] <= sample1;
                  smp_q[2] <= sample2;
                  smp_q[3] <= sample3;
                  vol_q[0] <= volume0;
                  vol_q[1] <= volume1;
                  vol_q[2] <= volume2;
                  vol_q[3] <= volume3;
                  en_q     <= chan_en;
                  acc_l_q  <= {MIX_W{1'b0}};
                  acc_r_q  <= {MIX_W{1'b0}};
                  ch_q     <= 2'd0;
                  state_q  <= ST_MUL;
                  busy_q   <= 1'b1;
               end else begin
                  busy_q   <= 1'b0;
               end
            end
            ST_MUL: begin
               overrun_q <= start;
               acc_l_q   <= acc_l_d;
               acc_r_q   <= acc_r_d;
               ch_q      <= ch_q + 2'd1;
               if (ch_q == 2'd3) begin
                  state_q <= ST_OUT;
               end else begin
                  state_q <= ST_MUL;
               end
            end
            ST_OUT: begin
               overrun_q <= start;
               left_q    <= acc_l_q;
               right_q   <= acc_r_q;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign left    = left_q;
   assign right   = right_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_paula_audio_mix_seq.sv
// Directed and randomized checks of the audio mix sequencer against an
// arithmetic reference model of the left/right mix.
module tb_paula_audio_mix_seq;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic signed [7:0] sample0, sample1, sample2, sample3;
   logic        [5:0] volume0, volume1, volume2, volume3;
   logic        [3:0] chan_en;
   logic signed [14:0] left, right;
   logic              done, busy, overrun;

   int n_chk = 0;
   int n_err = 0;
   int smp [4];
   int vol [4];
   logic [3:0] en;
   int exp_l, exp_r, lat, ndone;

   paula_audio_mix_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .sample0(sample0), .sample1(sample1), .sample2(sample2), .sample3(sample3),
      .volume0(volume0), .volume1(volume1), .volume2(volume2), .volume3(volume3),
      .chan_en(chan_en), .left(left), .right(right),
      .done(done), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Left gets channels 0 and 3, right gets 1 and 2; disabled channels add nothing.
   task automatic model(output int l, output int r);
      l = 0;
      r = 0;
      for (int c = 0; c < 4; c++) begin
         int t;
         t = en[c] ? smp[c] * vol[c] : 0;
         if (c == 0 || c == 3) l += t;
         else r += t;
      end
   endtask

   task automatic apply();
      sample0 = 8'(smp[0]); sample1 = 8'(smp[1]);
      sample2 = 8'(smp[2]); sample3 = 8'(smp[3]);
      volume0 = 6'(vol[0]); volume1 = 6'(vol[1]);
      volume2 = 6'(vol[2]); volume3 = 6'(vol[3]);
      chan_en = en;
   endtask

   task automatic scramble();
      sample0 = 8'($urandom); sample1 = 8'($urandom);
      sample2 = 8'($urandom); sample3 = 8'($urandom);
      volume0 = 6'($urandom); volume1 = 6'($urandom);
      volume2 = 6'($urandom); volume3 = 6'($urandom);
      chan_en = 4'($urandom);
   endtask

   // Pulse start with the applied inputs, wait for done and check latency and result.
   task automatic run_mix(input string tag, input bit change_after);
      model(exp_l, exp_r);
      @(negedge clk);
      apply();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (change_after) scramble();
      chk({tag, "_busy"}, int'(busy), 1);
      lat = 0;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 5);
      chk({tag, "_left"}, int'(left), exp_l);
      chk({tag, "_right"}, int'(right), exp_r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      smp = '{0, 0, 0, 0};
      vol = '{0, 0, 0, 0};
      en  = 4'b0000;
      apply();
      repeat (3) @(negedge clk);
      chk("rst_left", int'(left), 0);
      chk("rst_right", int'(right), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      reset_n = 1'b1;

      smp = '{127, -128, 64, -1};
      vol = '{63, 63, 32, 10};
      en  = 4'b1111;
      run_mix("single", 1'b0);
      chk("single_left_const", int'(left), 7991);
      chk("single_right_const", int'(right), -6016);
      @(negedge clk);
      chk("single_done_pulse", int'(done), 0);
      chk("single_busy_low", int'(busy), 0);

      smp = '{-128, -128, -128, -128};
      vol = '{63, 63, 63, 63};
      run_mix("neg_ext", 1'b0);
      chk("neg_ext_const", int'(left), -16128);
      smp = '{127, 127, 127, 127};
      run_mix("pos_ext", 1'b0);
      chk("pos_ext_const", int'(right), 16002);

      smp = '{127, -128, 64, -1};
      vol = '{63, 63, 32, 10};
      en  = 4'b0110;
      run_mix("mask", 1'b0);
      chk("mask_left_const", int'(left), 0);
      chk("mask_right_const", int'(right), -6016);

      // Overrun: second start sampled at E3 must be dropped.
      en = 4'b1111;
      smp = '{10, 20, -30, 40};
      vol = '{5, 6, 7, 8};
      model(exp_l, exp_r);
      @(negedge clk);
      apply();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ovr_pulse", int'(overrun), 1);
      chk("ovr_no_done", int'(done), 0);
      @(negedge clk);
      chk("ovr_clear", int'(overrun), 0);
      @(negedge clk);
      chk("ovr_done", int'(done), 1);
      chk("ovr_left", int'(left), exp_l);
      chk("ovr_right", int'(right), exp_r);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("ovr_single_done", ndone, 0);
      chk("ovr_busy_low", int'(busy), 0);

      smp = '{-77, 100, 33, -5};
      vol = '{40, 17, 63, 1};
      en  = 4'b1011;
      run_mix("snapshot", 1'b1);

      for (int it = 0; it < 20; it++) begin
         for (int c = 0; c < 4; c++) begin
            smp[c] = int'($urandom_range(255)) - 128;
            vol[c] = int'($urandom_range(63));
         end
         en = 4'($urandom);
         if (it == 0) vol = '{0, 0, 0, 0};
         run_mix("random", 1'b0);
      end

      // Reset mid-mix after a nonzero result is on the outputs.
      smp = '{50, 50, 50, 50};
      vol = '{50, 50, 50, 50};
      en  = 4'b1111;
      run_mix("pre_reset", 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_left", int'(left), 0);
      chk("abort_right", int'(right), 0);
      chk("abort_busy", int'(busy), 0);
      ndone = 0;
      repeat (2) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_left_hold", int'(left), 0);
      smp = '{-1, 2, -3, 4};
      vol = '{9, 8, 7, 6};
      run_mix("after_reset", 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
